ant_launcher: RTL and testbench

- Local-port endpoint paired with each ant_agent router node.
- Originates forward ant packets towards every other node in round-robin order and injects them into the router local input.
- Consumes the backward ants that the router delivers on its local output (output request 5'b10000) and reports round-trip latency for each.
- Tracks outstanding ants, retires ants that never return, and counts launches, returns, timeouts and strays.

---
 rtl/ant_launcher.sv | 209 ++++++++++++++++++++
 tb/tb_ant_launcher.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_launcher.sv
// Local-port ant endpoint: launches forward ants round-robin, matches returning
// backward ants to outstanding slots, and reports round-trip latency.
`ifndef X_NODES
`define X_NODES 2
`endif
`ifndef Y_NODES
`define Y_NODES 2
`endif
`ifndef NODES
`define NODES (`X_NODES*`Y_NODES)
`endif

package ant_pkg;
  localparam int XN  = `X_NODES;
  localparam int YN  = `Y_NODES;
  localparam int NN  = `NODES;
  localparam int XW  = (XN > 1) ? $clog2(XN) : 1;
  localparam int YW  = (YN > 1) ? $clog2(YN) : 1;
  localparam int IDW = (NN > 1) ? $clog2(NN) : 1;
  localparam int MW  = $clog2(NN + 1);

  typedef struct packed {
    logic                    ant;
    logic                    backward;
    logic [XW-1:0]           x_source;
    logic [YW-1:0]           y_source;
    logic [XW-1:0]           x_dest;
    logic [YW-1:0]           y_dest;
    logic [MW-1:0]           num_memories;
    logic [NN-1:0][IDW-1:0]  memories;
    logic [15:0]             payload;
  } packet_t;
endpackage

module ant_launcher
  import ant_pkg::*;
#(
  parameter int X_LOC           = 0,
  parameter int Y_LOC           = 0,
  parameter int ANT_PERIOD      = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  output packet_t         o_data,
  output logic            o_data_val,
  input  logic            i_data_ready,
  input  packet_t         i_data,
  input  logic            i_data_val,
  output logic            o_ant_done,
  output logic [IDW-1:0]  o_ant_dest,
  output logic [15:0]     o_rtt,
  output logic [15:0]     o_launched,
  output logic [15:0]     o_returned,
  output logic [15:0]     o_timeouts,
  output logic [15:0]     o_strays
);
  localparam int MAXO = MAX_OUTSTANDING;
  localparam int OWN  = Y_LOC * XN + X_LOC;
  localparam int CW   = (ANT_PERIOD > 2) ? $clog2(ANT_PERIOD - 1) : 1;
  localparam int SW   = (MAXO > 1) ? $clog2(MAXO) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, SEND} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [15:0]                now;
  logic [IDW-1:0]             ptr, ptr_nxt;
  logic [MAXO-1:0]            valid;
  logic [MAXO-1:0][IDW-1:0]   slot_dest;
  logic [MAXO-1:0][15:0]      slot_ts;
  logic [MAXO-1:0][15:0]      age;
  logic [MAXO-1:0]            ret_free, to_free, alloc_vec;
  logic [15:0]                to_cnt, best_age;
  logic [SW-1:0]              match_idx, alloc_idx;
  logic                       ret_hit, match, any_free, hs;
  logic [IDW-1:0]             src_id;
  packet_t                    fwd_pkt;
  logic                       unused_bits;

  assign unused_bits = ^{i_data.num_memories, i_data.memories, i_data.payload};
  assign hs       = o_data_val & i_data_ready;
  assign any_free = ~&valid;
  assign ret_hit  = i_data_val & i_data.ant & i_data.backward &
                    (i_data.x_dest == XW'(X_LOC)) & (i_data.y_dest == YW'(Y_LOC));
  assign src_id   = IDW'(int'(i_data.y_source) * XN + int'(i_data.x_source));

  always_comb begin
    fwd_pkt          = '0;
    fwd_pkt.ant      = 1'b1;
    fwd_pkt.x_source = XW'(X_LOC);
    fwd_pkt.y_source = YW'(Y_LOC);
    fwd_pkt.x_dest   = XW'(int'(ptr) % XN);
    fwd_pkt.y_dest   = YW'(int'(ptr) / XN);
  end

  // Next destination wraps modulo node count and never targets this node.
  always_comb begin
    ptr_nxt = (int'(ptr) == NN - 1) ? '0 : ptr + IDW'(1);
    if (int'(ptr_nxt) == OWN)
      ptr_nxt = (int'(ptr_nxt) == NN - 1) ? '0 : ptr_nxt + IDW'(1);
  end

  // Oldest matching slot wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    best_age  = '0;
    ret_free  = '0;
    for (int i = 0; i < MAXO; i++) begin
      age[i] = now - slot_ts[i];
      if (ret_hit && valid[i] && slot_dest[i] == src_id && (!match || age[i] > best_age)) begin
        match     = 1'b1;
        match_idx = SW'(i);
        best_age  = age[i];
      end
    end
    if (match) ret_free[match_idx] = 1'b1;
  end

  always_comb begin
    to_cnt    = '0;
    alloc_idx = '0;
    alloc_vec = '0;
    for (int i = 0; i < MAXO; i++) begin
      to_free[i] = valid[i] && (age[i] >= 16'(TIMEOUT)) && !ret_free[i];
      to_cnt     = to_cnt + {15'd0, to_free[i]};
    end
    for (int i = MAXO - 1; i >= 0; i--)
      if (!valid[i]) alloc_idx = SW'(i);
    if (hs) alloc_vec[alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      now        <= '0;
      ptr        <= IDW'((OWN + 1) % NN);
      valid      <= '0;
      slot_dest  <= '0;
      slot_ts    <= '0;
      o_data     <= '0;
      o_data_val <= 1'b0;
      o_ant_done <= 1'b0;
      o_ant_dest <= '0;
      o_rtt      <= '0;
      o_launched <= '0;
      o_returned <= '0;
      o_timeouts <= '0;
      o_strays   <= '0;
    end else begin
      now        <= now + 16'd1;
      o_ant_done <= 1'b0;
      if (match) begin
        o_ant_done <= 1'b1;
        o_ant_dest <= src_id;
        o_rtt      <= age[match_idx];
        o_returned <= o_returned + 16'd1;
      end else if (ret_hit) begin
        o_strays <= o_strays + 16'd1;
      end
      o_timeouts <= o_timeouts + to_cnt;
      // Allocation picks from the pre-free vector, so it never collides with a free.
      valid <= (valid & ~ret_free & ~to_free) | alloc_vec;

      case (state)
        IDLE: begin
          if (!i_en) begin
            cnt <= '0;
          end else if (cnt == CW'(ANT_PERIOD - 2)) begin
            cnt <= '0;
            if (any_free) begin
              state      <= SEND;
              o_data     <= fwd_pkt;
              o_data_val <= 1'b1;
            end else begin
              state <= WAIT_SLOT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_SLOT: begin
          if (!i_en) begin
            state <= IDLE;
          end else if (any_free) begin
            state      <= SEND;
            o_data     <= fwd_pkt;
            o_data_val <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            state                <= IDLE;
            o_data_val           <= 1'b0;
            o_launched           <= o_launched + 16'd1;
            ptr                  <= ptr_nxt;
            slot_dest[alloc_idx] <= ptr;
            slot_ts[alloc_idx]   <= now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ant_launcher.sv
// Bench for ant_launcher on a 2x2 mesh at node (0,0): directed scenarios plus
// a randomized run against a queue-based model of outstanding ants.
module tb_ant_launcher;
  import ant_pkg::*;

  localparam int OWN  = 0;
  localparam int P    = 4;
  localparam int MAXO = 4;
  localparam int TO   = 40;

  logic            clk = 1'b0;
  logic            reset, i_en, i_data_ready, i_data_val;
  packet_t         i_data, o_data;
  logic            o_data_val, o_ant_done;
  logic [IDW-1:0]  o_ant_dest;
  logic [15:0]     o_rtt, o_launched, o_returned, o_timeouts, o_strays;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding ants in launch order (front = oldest).
  int          q_dest[$];
  logic [15:0] q_ts[$];
  int          m_ptr, m_dest;
  logic [15:0] m_launched, m_returned, m_timeouts, m_strays, m_rtt, tnow;
  logic        m_done;

  ant_launcher #(.X_LOC(0), .Y_LOC(0), .ANT_PERIOD(P), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_en(i_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_data_ready(i_data_ready),
    .i_data(i_data), .i_data_val(i_data_val),
    .o_ant_done(o_ant_done), .o_ant_dest(o_ant_dest), .o_rtt(o_rtt),
    .o_launched(o_launched), .o_returned(o_returned),
    .o_timeouts(o_timeouts), .o_strays(o_strays)
  );

  always #5 clk = ~clk;

  function automatic packet_t mk_pkt(input logic ant, input logic bwd, input int src, input int dst);
    packet_t p;
    p          = '0;
    p.ant      = ant;
    p.backward = bwd;
    p.x_source = XW'(src % XN);
    p.y_source = YW'(src / XN);
    p.x_dest   = XW'(dst % XN);
    p.y_dest   = YW'(dst / XN);
    return p;
  endfunction

  function automatic packet_t exp_pkt(input int d);
    return mk_pkt(1'b1, 1'b0, OWN, d);
  endfunction

  task automatic m_reset();
    q_dest.delete();
    q_ts.delete();
    m_ptr = (OWN + 1) % NN;
    m_launched = '0; m_returned = '0; m_timeouts = '0; m_strays = '0;
    m_done = 1'b0; m_dest = 0; m_rtt = '0; tnow = '0;
  endtask

  // Advance one clock; the model consumes the values present before the edge.
  task automatic step();
    logic        done_n;
    logic [15:0] age;
    int          src, hit;
    done_n = 1'b0;
    if (!reset) begin
      if (i_data_val && i_data.ant && i_data.backward && int'(i_data.x_dest) == OWN % XN &&
          int'(i_data.y_dest) == OWN / XN) begin
        src = int'(i_data.y_source) * XN + int'(i_data.x_source);
        hit = -1;
        for (int k = 0; k < q_dest.size(); k++)
          if (hit < 0 && q_dest[k] == src) hit = k;
        if (hit >= 0) begin
          done_n = 1'b1;
          m_dest = src;
          m_rtt  = tnow - q_ts[hit];
          m_returned = m_returned + 16'd1;
          q_dest.delete(hit);
          q_ts.delete(hit);
        end else begin
          m_strays = m_strays + 16'd1;
        end
      end
      for (int k = q_dest.size() - 1; k >= 0; k--) begin
        age = tnow - q_ts[k];
        if (age >= 16'(TO)) begin
          q_dest.delete(k);
          q_ts.delete(k);
          m_timeouts = m_timeouts + 16'd1;
        end
      end
      if (o_data_val && i_data_ready) begin
        q_dest.push_back(m_ptr);
        q_ts.push_back(tnow);
        m_launched = m_launched + 16'd1;
        m_ptr = (m_ptr + 1) % NN;
        if (m_ptr == OWN) m_ptr = (m_ptr + 1) % NN;
      end
    end
    @(posedge clk);
    if (reset) m_reset();
    else tnow = tnow + 16'd1;
    m_done = done_n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_en = 1'b0; i_data_ready = 1'b0; i_data_val = 1'b0; i_data = '0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({o_data_val, o_ant_done, o_ant_dest, o_rtt} !== '0) begin
      errors++; $display("FAIL reset_out: got val=%0b done=%0b dest=%0d rtt=%0d exp all 0",
                         o_data_val, o_ant_done, o_ant_dest, o_rtt);
    end
    checks++;
    if ({o_launched, o_returned, o_timeouts, o_strays} !== 64'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d exp 0/0/0/0",
                         o_launched, o_returned, o_timeouts, o_strays);
    end
    checks++;
    if (o_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", o_data);
    end
  endtask

  task automatic test_rr_launch();
    int lt[$];
    int ld[$];
    int exp_d[4] = '{1, 2, 3, 1};
    i_en = 1'b1; i_data_ready = 1'b1;
    for (int c = 0; c < 60 && lt.size() < 4; c++) begin
      if (o_data_val) begin
        checks++;
        if (o_data !== exp_pkt(m_ptr)) begin
          errors++; $display("FAIL rr_pkt: got %h exp %h", o_data, exp_pkt(m_ptr));
        end
        lt.push_back(int'(tnow));
        ld.push_back(int'(o_data.y_dest) * XN + int'(o_data.x_dest));
        step();
        checks++;
        if (o_data_val !== 1'b0) begin
          errors++; $display("FAIL rr_val_drop: got %0b exp 0", o_data_val);
        end
      end else begin
        step();
      end
    end
    i_en = 1'b0;
    checks++;
    if (lt.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d launches exp 4", lt.size());
    end else begin
      checks++;
      if (lt[0] != P - 1) begin
        errors++; $display("FAIL rr_first: got cycle %0d exp %0d", lt[0], P - 1);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ld[k] != exp_d[k]) begin
          errors++; $display("FAIL rr_dest%0d: got %0d exp %0d", k, ld[k], exp_d[k]);
        end
        if (k > 0) begin
          checks++;
          if (lt[k] - lt[k-1] != P) begin
            errors++; $display("FAIL rr_spacing%0d: got %0d exp %0d", k, lt[k] - lt[k-1], P);
          end
        end
      end
    end
    checks++;
    if (o_launched !== 16'd4) begin
      errors++; $display("FAIL rr_launched: got %0d exp 4", o_launched);
    end
  endtask

  task automatic test_return();
    logic [15:0] t0, rtt_hold;
    // The ant to node 2 was the second launch, at cycle 2*P-1.
    t0 = tnow;
    i_data = mk_pkt(1'b1, 1'b1, 2, OWN); i_data_val = 1'b1;
    step();
    i_data_val = 1'b0;
    checks++;
    if (o_ant_done !== 1'b1 || int'(o_ant_dest) != 2) begin
      errors++; $display("FAIL ret_pulse: got done=%0b dest=%0d exp done=1 dest=2", o_ant_done, o_ant_dest);
    end
    checks++;
    if (o_rtt !== t0 - 16'(2 * P - 1) || o_rtt !== m_rtt) begin
      errors++; $display("FAIL ret_rtt: got %0d exp %0d", o_rtt, t0 - 16'(2 * P - 1));
    end
    checks++;
    if (o_returned !== 16'd1) begin
      errors++; $display("FAIL ret_count: got %0d exp 1", o_returned);
    end
    rtt_hold = o_rtt;
    step();
    checks++;
    if (o_ant_done !== 1'b0 || o_rtt !== rtt_hold || int'(o_ant_dest) != 2) begin
      errors++; $display("FAIL ret_hold: got done=%0b rtt=%0d dest=%0d exp done=0 rtt=%0d dest=2",
                         o_ant_done, o_rtt, o_ant_dest, rtt_hold);
    end
  endtask

  task automatic test_stray_ignore();
    i_data = mk_pkt(1'b1, 1'b1, 2, OWN); i_data_val = 1'b1;
    step();
    checks++;
    if (o_strays !== 16'd1 || o_ant_done !== 1'b0) begin
      errors++; $display("FAIL stray: got strays=%0d done=%0b exp strays=1 done=0", o_strays, o_ant_done);
    end
    i_data = mk_pkt(1'b0, 1'b1, 1, OWN);   // not an ant
    step();
    i_data = mk_pkt(1'b1, 1'b0, 3, OWN);   // forward ant
    step();
    i_data = mk_pkt(1'b1, 1'b1, 3, 3);     // addressed elsewhere
    step();
    i_data_val = 1'b0;
    checks++;
    if (o_strays !== 16'd1 || o_returned !== 16'd1 || o_timeouts !== m_timeouts || o_ant_done !== 1'b0) begin
      errors++; $display("FAIL ignore: got strays=%0d ret=%0d to=%0d exp 1/1/%0d",
                         o_strays, o_returned, o_timeouts, m_timeouts);
    end
  endtask

  task automatic test_wait_slot();
    int viol = 0;
    int full_seen = 0;
    logic [15:0] base;
    base = o_launched;
    i_en = 1'b1; i_data_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (q_dest.size() >= MAXO) full_seen = 1;
      if (o_data_val && q_dest.size() >= MAXO) viol++;
      step();
    end
    i_en = 1'b0;
    checks++;
    if (viol != 0 || full_seen != 1) begin
      errors++; $display("FAIL wait_full: got %0d launches while full (full_seen=%0d) exp 0 (1)", viol, full_seen);
    end
    checks++;
    if (o_timeouts !== m_timeouts || o_timeouts < 16'd3) begin
      errors++; $display("FAIL wait_timeouts: got %0d exp %0d (>=3)", o_timeouts, m_timeouts);
    end
    checks++;
    if (o_launched !== m_launched || o_launched < base + 16'd2) begin
      errors++; $display("FAIL wait_resume: got %0d exp %0d (>=%0d)", o_launched, m_launched, base + 16'd2);
    end
  endtask

  task automatic test_backpressure();
    packet_t cap;
    logic [15:0] base;
    int c;
    i_en = 1'b1; i_data_ready = 1'b0;
    c = 0;
    while (!o_data_val && c < 100) begin step(); c++; end
    checks++;
    if (!o_data_val) begin
      errors++; $display("FAIL bp_send: got no o_data_val within 100 cycles exp 1");
    end
    cap = o_data; base = o_launched;
    i_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_data_val !== 1'b1 || o_data !== cap) begin
        errors++; $display("FAIL bp_hold%0d: got val=%0b data=%h exp val=1 data=%h", k, o_data_val, o_data, cap);
      end
      if (k == 5) i_data_ready = 1'b1;
      step();
    end
    step();
    step();
    checks++;
    if (o_data_val !== 1'b0 || o_launched !== base + 16'd1) begin
      errors++; $display("FAIL bp_once: got val=%0b launched=%0d exp val=0 launched=%0d",
                         o_data_val, o_launched, base + 16'd1);
    end
    // Reset while a launch is pending must discard it.
    i_en = 1'b1; i_data_ready = 1'b0;
    c = 0;
    while (!o_data_val && c < 100) begin step(); c++; end
    reset = 1'b1; i_data_ready = 1'b1;
    step();
    reset = 1'b0; i_en = 1'b0;
    checks++;
    if (o_data_val !== 1'b0 || o_launched !== 16'd0 || o_timeouts !== 16'd0) begin
      errors++; $display("FAIL midsend_reset: got val=%0b launched=%0d to=%0d exp 0/0/0",
                         o_data_val, o_launched, o_timeouts);
    end
  endtask

  task automatic test_ret_timeout_same();
    logic [15:0] lt;
    int c;
    i_en = 1'b1; i_data_ready = 1'b1;
    lt = '0;
    c = 0;
    while (!o_data_val && c < 50) begin step(); c++; end
    lt = tnow;
    step();
    i_en = 1'b0;
    c = 0;
    while (tnow != lt + 16'(TO) && c < 200) begin step(); c++; end
    i_data = mk_pkt(1'b1, 1'b1, 1, OWN); i_data_val = 1'b1;
    step();
    i_data_val = 1'b0;
    checks++;
    if (o_ant_done !== 1'b1 || o_rtt !== 16'(TO) || o_returned !== 16'd1) begin
      errors++; $display("FAIL same_cycle_ret: got done=%0b rtt=%0d ret=%0d exp 1/%0d/1",
                         o_ant_done, o_rtt, o_returned, TO);
    end
    step();
    step();
    checks++;
    if (o_timeouts !== 16'd0 || o_timeouts !== m_timeouts) begin
      errors++; $display("FAIL same_cycle_to: got %0d exp 0", o_timeouts);
    end
  endtask

  task automatic test_random();
    logic pv, pr, prst;
    pv = 1'b0; pr = 1'b0; prst = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      i_en         = ($urandom_range(0, 9) < 8);
      i_data_ready = ($urandom_range(0, 9) < 7);
      i_data_val   = ($urandom_range(0, 9) < 4);
      i_data = mk_pkt($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                      $urandom_range(0, NN - 1),
                      ($urandom_range(0, 9) < 8) ? OWN : $urandom_range(0, NN - 1));
      i_data.payload = 16'($urandom);
      if (pv && !pr && !prst) begin
        checks++;
        if (o_data_val !== 1'b1) begin
          errors++; $display("FAIL rnd_hold c%0d: got val=%0b exp 1", c, o_data_val);
        end
      end
      if (o_data_val) begin
        checks++;
        if (o_data !== exp_pkt(m_ptr) || q_dest.size() >= MAXO) begin
          errors++; $display("FAIL rnd_pkt c%0d: got %h exp %h (outstanding %0d)",
                             c, o_data, exp_pkt(m_ptr), q_dest.size());
        end
      end
      pv = o_data_val; pr = i_data_ready; prst = reset;
      step();
      checks++;
      if (o_ant_done !== m_done || int'(o_ant_dest) != m_dest || o_rtt !== m_rtt) begin
        errors++; $display("FAIL rnd_ret c%0d: got done=%0b dest=%0d rtt=%0d exp %0b/%0d/%0d",
                           c, o_ant_done, o_ant_dest, o_rtt, m_done, m_dest, m_rtt);
      end
      checks++;
      if (o_launched !== m_launched || o_returned !== m_returned ||
          o_timeouts !== m_timeouts || o_strays !== m_strays) begin
        errors++; $display("FAIL rnd_cnt c%0d: got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", c,
                           o_launched, o_returned, o_timeouts, o_strays,
                           m_launched, m_returned, m_timeouts, m_strays);
      end
    end
    reset = 1'b0; i_data_val = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_en = 1'b0; i_data_ready = 1'b0; i_data_val = 1'b0; i_data = '0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_rr_launch();
    test_return();
    test_stray_ignore();
    test_wait_slot();
    test_backpressure();
    test_ret_timeout_same();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
